// File: rtl/imemory_access.sv
// MIPS MEM stage: word-addressed data RAM, branch resolution back to fetch,
// and the MEM/WB pipeline register. Debug port reads RAM without side effects.
module imemory_access #(
  parameter int unsigned ADDR_BITS     = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MEM_BUS_WIDTH = 3,
  parameter int unsigned WB_BUS_WIDTH  = 2,
  parameter int unsigned MEM_ADDR_BITS = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [MEM_BUS_WIDTH-1:0] memory_bus_in,
  input  logic [WB_BUS_WIDTH-1:0]  wb_bus_in,
  input  logic [DATA_WIDTH-1:0]    alu_result_in,
  input  logic [DATA_WIDTH-1:0]    reg_rt_data_in,
  input  logic [ADDR_BITS-1:0]     add_reg_w_in,
  input  logic [ADDR_BITS-1:0]     next_pc_in,
  input  logic                     alu_zero_flag,
  input  logic [MEM_ADDR_BITS-1:0] debug_addr_in,
  output logic [DATA_WIDTH-1:0]    read_data_out,
  output logic [DATA_WIDTH-1:0]    alu_result_out,
  output logic [ADDR_BITS-1:0]     add_reg_w_out,
  output logic [WB_BUS_WIDTH-1:0]  wb_bus_out,
  output logic                     misaligned_out,
  output logic                     pc_src_out,
  output logic [ADDR_BITS-1:0]     branch_target_out,
  output logic [DATA_WIDTH-1:0]    debug_data_out
);

  localparam int unsigned DEPTH = 1 << MEM_ADDR_BITS;

  logic [DATA_WIDTH-1:0]    r_ram [DEPTH];
  logic [DATA_WIDTH-1:0]    r_read_data;
  logic [DATA_WIDTH-1:0]    r_alu_result;
  logic [ADDR_BITS-1:0]     r_add_reg_w;
  logic [WB_BUS_WIDTH-1:0]  r_wb_bus;
  logic                     r_misaligned;

  logic                     w_branch;
  logic                     w_mem_read;
  logic                     w_mem_write;
  logic                     w_aligned;
  logic [MEM_ADDR_BITS-1:0] w_index;

  assign w_branch    = memory_bus_in[0];
  assign w_mem_read  = memory_bus_in[1];
  assign w_mem_write = memory_bus_in[2];
  assign w_aligned   = (alu_result_in[1:0] == 2'b00);
  // Upper address bits are dropped so accesses wrap modulo RAM depth.
  assign w_index     = alu_result_in[MEM_ADDR_BITS+1:2];

  // Data RAM write port; contents intentionally have no reset.
  always_ff @(posedge clk) begin
    if (enable && w_mem_write && w_aligned) begin
      r_ram[w_index] <= reg_rt_data_in;
    end
  end

  // MEM/WB register; load data samples the pre-write word (read-before-write).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_read_data  <= '0;
      r_alu_result <= '0;
      r_add_reg_w  <= '0;
      r_wb_bus     <= '0;
      r_misaligned <= 1'b0;
    end else if (enable) begin
      r_read_data  <= (w_mem_read && w_aligned) ? r_ram[w_index] : '0;
      r_alu_result <= alu_result_in;
      r_add_reg_w  <= add_reg_w_in;
      r_wb_bus     <= wb_bus_in;
      r_misaligned <= (w_mem_read | w_mem_write) & ~w_aligned;
    end
  end

  assign read_data_out     = r_read_data;
  assign alu_result_out    = r_alu_result;
  assign add_reg_w_out     = r_add_reg_w;
  assign wb_bus_out        = r_wb_bus;
  assign misaligned_out    = r_misaligned;

  // Branch resolution is combinational so fetch redirects in the same cycle.
  assign pc_src_out        = enable & w_branch & alu_zero_flag;
  assign branch_target_out = next_pc_in;
  assign debug_data_out    = r_ram[debug_addr_in];

endmodule
